acc_ram_march_bist: RTL and testbench

Built-in self-test controller that sits directly in front of the accumulator RAM (synchronous write port, asynchronous read port) and drives both of its ports during test. On `start` it runs a March C- sequence over every word and compares each read against the expected background in the same cycle. It reports pass/fail, the first failing address and element, and a saturating failure count. In functional mode the datapath muxes RAM ports away from this block. This block only guarantees `ram_wr_en=0` whenever it is not busy.

---
 rtl/acc_ram_march_bist_if.sv | 28 ++
 rtl/acc_ram_march_bist.sv | 181 ++++++++++++++++++
 tb/tb_acc_ram_march_bist.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_ram_march_bist_if.sv
// acc_ram_march_bist_if: accumulator RAM test port.
// The BIST drives the RAM through master; the RAM answers as slave.
interface acc_ram_march_bist_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    output ram_wr_en,
    output ram_wr_addr,
    output ram_din,
    output ram_rd_addr,
    input  ram_dout
  );

  modport slave (
    input  ram_wr_en,
    input  ram_wr_addr,
    input  ram_din,
    input  ram_rd_addr,
    output ram_dout
  );
endinterface

// File: rtl/acc_ram_march_bist.sv
// acc_ram_march_bist: March C- self-test controller for the accumulator RAM.
// Define BIST_CHECKERBOARD_EN to add a second pass on a 0101... background.
module acc_ram_march_bist #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [3:0]            fail_elem,
  output logic [7:0]            fail_count,
  acc_ram_march_bist_if.master  ram
);

  typedef enum logic [2:0] {
    S_M0   = 3'd0,
    S_M1   = 3'd1,
    S_M2   = 3'd2,
    S_M3   = 3'd3,
    S_M4   = 3'd4,
    S_M5   = 3'd5,
    S_IDLE = 3'd6,
    S_DONE = 3'd7
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(ARRAY_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);

  state_t                  state, state_nxt;
  logic                    phase, phase_nxt;
  logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
  logic                    bg, bg_nxt;
  logic [DATA_WIDTH-1:0]   bgnd;
  logic                    two_op;
  logic                    down;
  logic                    at_end;
  logic                    elem_end;
  logic                    rd_cyc;
  logic [DATA_WIDTH-1:0]   exp_v;
  logic                    mm;

`ifdef BIST_CHECKERBOARD_EN
  localparam logic [DATA_WIDTH-1:0] CHK =
    DATA_WIDTH'({(DATA_WIDTH + 1) / 2{2'b01}});
  localparam logic HAS_CHK = 1'b1;
  assign bgnd = bg ? CHK : '0;
`else
  localparam logic HAS_CHK = 1'b0;
  assign bgnd = '0;
`endif

  assign two_op = (state == S_M1) || (state == S_M2) ||
                  (state == S_M3) || (state == S_M4);
  assign down   = (state == S_M3) || (state == S_M4);
  assign at_end = down ? (addr == '0) : (addr == LAST);
  // Two-op elements finish on the write half of the last address
  assign elem_end = at_end && (!two_op || phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      phase <= 1'b0;
      addr  <= '0;
      bg    <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      addr  <= addr_nxt;
      bg    <= bg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    addr_nxt  = addr;
    bg_nxt    = bg;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_M0;
          phase_nxt = 1'b0;
          addr_nxt  = '0;
          bg_nxt    = 1'b0;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: begin
        if (two_op && !phase) begin
          phase_nxt = 1'b1;
        end else if (!elem_end) begin
          phase_nxt = 1'b0;
          addr_nxt  = down ? addr - ONE : addr + ONE;
        end else begin
          phase_nxt = 1'b0;
          unique case (state)
            S_M0: begin
              state_nxt = S_M1;
              addr_nxt  = '0;
            end
            S_M1: begin
              state_nxt = S_M2;
              addr_nxt  = '0;
            end
            S_M2: begin
              state_nxt = S_M3;
              addr_nxt  = LAST;
            end
            S_M3: begin
              state_nxt = S_M4;
              addr_nxt  = LAST;
            end
            S_M4: begin
              state_nxt = S_M5;
              addr_nxt  = '0;
            end
            default: begin
              addr_nxt = '0;
              if (HAS_CHK && !bg) begin
                state_nxt = S_M0;
                bg_nxt    = 1'b1;
              end else begin
                state_nxt = S_DONE;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE) && (state != S_DONE);
    done   = (state == S_DONE);
    rd_cyc = (two_op && !phase) || (state == S_M5);
    exp_v  = ((state == S_M2) || (state == S_M4)) ? ~bgnd : bgnd;
    ram.ram_wr_en   = (state == S_M0) || (two_op && phase);
    ram.ram_wr_addr = addr;
    ram.ram_rd_addr = addr;
    ram.ram_din     = ((state == S_M1) || (state == S_M3)) ? ~bgnd : bgnd;
    mm = rd_cyc && (ram.ram_dout != exp_v);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else if (state == S_IDLE && start) begin
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else begin
      if (mm) begin
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= addr;
          fail_elem <= {bg, 3'(state)};
        end
      end
      // Include a mismatch on the very last read in the verdict
      if (state_nxt == S_DONE) begin
        pass <= (fail_count == 8'd0) && !mm;
      end
    end
  end

endmodule

// File: tb/tb_acc_ram_march_bist.sv
// tb_acc_ram_march_bist: scoreboard bench with a fault-injecting RAM
// and an array-based March C- reference model.
module tb_acc_ram_march_bist;
  localparam int DW = 32;
  localparam int N  = 16;
  localparam int AW = $clog2(N);
`ifdef BIST_CHECKERBOARD_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  localparam int RUN = 10 * N * NP;
  localparam logic [DW-1:0] CHK = 32'h5555_5555;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, fail;
  logic [AW-1:0] fail_addr;
  logic [3:0]    fail_elem;
  logic [7:0]    fail_count;

  acc_ram_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  acc_ram_march_bist #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_count(fail_count),
    .ram       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {F_NONE, F_SA, F_DEC} flt_t;
  flt_t flt = F_NONE;
  int   fa = 0, fb = 1, fbit = 0;
  logic fval = 1'b0;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_v;

  always @(posedge clk) begin
    if (bus.ram_wr_en) begin
      mem[bus.ram_wr_addr] <= bus.ram_din;
      if (flt == F_DEC && int'(bus.ram_wr_addr) == fa)
        mem[fb] <= bus.ram_din;
    end
  end

  always_comb begin
    rd_v = mem[bus.ram_rd_addr];
    if (flt == F_SA && int'(bus.ram_rd_addr) == fa) rd_v[fbit] = fval;
  end
  assign bus.ram_dout = rd_v;

  typedef struct {
    int xcyc;
    bit xpass;
    bit xfail;
    int xaddr;
    int xelem;
    int xcnt;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, busy_cnt = 0;
  bit last_pass = 0;

  task automatic chk(string nm, longint act, longint want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  function automatic exp_t model(int c1);
    logic [DW-1:0] m [N];
    logic [DW-1:0] b, v, d;
    int rdk [6] = '{-1, 0, 1, 0, 1, 0};
    int wrk [6] = '{0, 1, 0, 1, 0, -1};
    bit dn  [6] = '{0, 0, 0, 1, 1, 0};
    int a;
    exp_t e;
    e.xcyc = c1 + RUN;
    e.xaddr = 0;
    e.xelem = 0;
    e.xcnt = 0;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int p = 0; p < NP; p++) begin
      b = (p == 1) ? CHK : '0;
      for (int el = 0; el < 6; el++) begin
        for (int i = 0; i < N; i++) begin
          a = dn[el] ? N - 1 - i : i;
          if (rdk[el] >= 0) begin
            v = m[a];
            if (flt == F_SA && a == fa) v[fbit] = fval;
            if (v != ((rdk[el] == 1) ? ~b : b)) begin
              if (e.xcnt == 0) begin
                e.xaddr = a;
                e.xelem = p * 8 + el;
              end
              if (e.xcnt < 255) e.xcnt++;
            end
          end
          if (wrk[el] >= 0) begin
            d = (wrk[el] == 1) ? ~b : b;
            m[a] = d;
            if (flt == F_DEC && a == fa) m[fb] = d;
          end
        end
      end
    end
    e.xfail = (e.xcnt != 0);
    e.xpass = (e.xcnt == 0);
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          chk("done_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.xcyc);
            chk("busy_cycles", busy_cnt, RUN);
            chk("pass", pass, e.xpass);
            chk("fail", fail, e.xfail);
            chk("fail_addr", fail_addr, e.xaddr);
            chk("fail_elem", fail_elem, e.xelem);
            chk("fail_count", fail_count, e.xcnt);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < RUN + 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic set_fault(flt_t t, int a, int b2, int bt, logic v);
    flt = t;
    fa = a;
    fb = b2;
    fbit = bt;
    fval = v;
  endtask

  task automatic run_test(int gap);
    exp_t e;
    repeat (gap) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e = model(cyc);
    last_pass = e.xpass;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("pass_hold", pass, last_pass);
  endtask

  initial begin
    int c1, d0;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_wr_en", bus.ram_wr_en, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_elem", fail_elem, 0);
    chk("rst_fail_count", fail_count, 0);
    rst = 1'b0;

    set_fault(F_NONE, 0, 1, 0, 1'b0);
    run_test(2);
    set_fault(F_SA, 5, 0, 0, 1'b1);
    run_test(1);
    set_fault(F_DEC, 3, 7, 0, 1'b0);
    run_test(0);
    set_fault(F_SA, 2, 0, 1, 1'b0);
    run_test(3);

    for (int k = 0; k < 8; k++) begin
      int a;
      a = int'($urandom_range(0, N - 1));
      set_fault(flt_t'($urandom_range(0, 2)), a,
                (a + int'($urandom_range(1, N - 1))) % N,
                int'($urandom_range(0, DW - 1)),
                1'($urandom_range(0, 1)));
      run_test(int'($urandom_range(0, 5)));
    end

    // Reset in cycle 50 of a run that has already logged a mismatch
    set_fault(F_SA, 0, 1, 0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c1 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c1 + 49) @(negedge clk);
    chk("abort_pre_count", fail_count, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", bus.ram_wr_en, 0);
    chk("abort_fail_count", fail_count, 0);
    rst = 1'b0;
    set_fault(F_NONE, 0, 1, 0, 1'b0);
    run_test(1);
    chk("after_abort_pass", pass, 1);

    // start held through the whole run
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c1 = cyc;
    q.push_back(model(c1));
    while (cyc < c1 + RUN) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_done_once", done_cnt - d0, 1);
    chk("held_idle", busy, 0);
    chk("held_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
